// File: rtl/lane_sync_ctrl.sv
// Lane synchronisation controller: sequences decoder reset, alignment hunt, lock verification and lane-up.
// Optional macro LANE_SYNC_CANDIDATE_CHECK_EN also treats an alignment-offset change as a lock loss.
module lane_sync_ctrl #(
    parameter int SETTLE_CYCLES = 16,
    parameter int LOCK_TIMEOUT  = 1024,
    parameter int STABLE_CYCLES = 32,
    parameter int RESET_HOLD    = 4,
    parameter int MAX_RETRIES   = 4
) (
    input  logic       USER_CLK,
    input  logic       SYSTEM_RESET,
    input  logic       RX_READY,
    input  logic       RESTART,
    input  logic       DEC_LOCKED,
    input  logic [6:0] DEC_CANDIDATE,
    output logic       DEC_PASSTHROUGH,
    output logic       DEC_DATA_VALID,
    output logic       LANE_UP,
    output logic       LOCK_TIMEOUT_ERR,
    output logic [7:0] RESYNC_CNT,
    output logic [2:0] STATE_OUT
);

    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] SETTLE      = 3'd1;
    localparam logic [2:0] HUNT        = 3'd2;
    localparam logic [2:0] VERIFY      = 3'd3;
    localparam logic [2:0] RESTART_DEC = 3'd4;
    localparam logic [2:0] UP          = 3'd5;
    localparam logic [2:0] FAIL        = 3'd6;

    localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] STABLE_LAST  = 16'(STABLE_CYCLES - 1);
    localparam logic [15:0] HOLD_LAST    = 16'(RESET_HOLD - 1);
    localparam logic [7:0]  RETRY_MAX    = 8'(MAX_RETRIES);

    logic [2:0]  state;
    logic [2:0]  state_nx;
    logic [15:0] settle_cnt;
    logic [15:0] timer;
    logic [15:0] stable_cnt;
    logic [15:0] hold_cnt;
    logic [7:0]  retry_cnt;
    logic        timeout_hit;
    logic        up_loss;
    logic        lock_bad;

`ifdef LANE_SYNC_CANDIDATE_CHECK_EN
    logic [6:0] cand_q;
    assign lock_bad = !DEC_LOCKED || (DEC_CANDIDATE != cand_q);
`else
    logic unused_candidate;
    assign unused_candidate = ^DEC_CANDIDATE;
    assign lock_bad = !DEC_LOCKED;
`endif

    assign STATE_OUT = state;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_nx    = state;
        timeout_hit = 1'b0;
        up_loss     = 1'b0;
        if (state != FAIL && !RX_READY) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:   state_nx = SETTLE;
                SETTLE: if (settle_cnt == SETTLE_LAST) state_nx = HUNT;
                HUNT: begin
                    if (DEC_LOCKED) begin
                        state_nx = VERIFY;
                    end else if (timer == TIMEOUT_LAST) begin
                        state_nx    = RESTART_DEC;
                        timeout_hit = 1'b1;
                    end
                end
                RESTART_DEC: begin
                    if (hold_cnt == HOLD_LAST)
                        state_nx = (retry_cnt == RETRY_MAX) ? FAIL : HUNT;
                end
                VERIFY: begin
                    if (lock_bad) state_nx = HUNT;
                    else if (stable_cnt == STABLE_LAST) state_nx = UP;
                end
                UP: begin
                    if (lock_bad) begin
                        state_nx = HUNT;
                        up_loss  = 1'b1;
                    end
                end
                FAIL:    if (RESTART) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge USER_CLK) begin
        if (SYSTEM_RESET) begin
            state            <= IDLE;
            settle_cnt       <= '0;
            timer            <= '0;
            stable_cnt       <= '0;
            hold_cnt         <= '0;
            retry_cnt        <= '0;
            RESYNC_CNT       <= '0;
            LOCK_TIMEOUT_ERR <= 1'b0;
            DEC_PASSTHROUGH  <= 1'b1;
            DEC_DATA_VALID   <= 1'b0;
            LANE_UP          <= 1'b0;
        end else begin
            state <= state_nx;

            if (state_nx != state) begin
                settle_cnt <= '0;
                timer      <= '0;
                stable_cnt <= '0;
                hold_cnt   <= '0;
            end else begin
                case (state)
                    SETTLE:      settle_cnt <= settle_cnt + 16'd1;
                    HUNT:        timer      <= timer + 16'd1;
                    VERIFY:      stable_cnt <= stable_cnt + 16'd1;
                    RESTART_DEC: hold_cnt   <= hold_cnt + 16'd1;
                    default: ;
                endcase
            end

            // Retries persist across HUNT/RESTART_DEC loops; only lane-up, FAIL exit or RX loss clear them.
            if (state != FAIL && !RX_READY)
                retry_cnt <= '0;
            else if (timeout_hit)
                retry_cnt <= retry_cnt + 8'd1;
            else if ((state == VERIFY && state_nx == UP) || (state == FAIL && state_nx == IDLE))
                retry_cnt <= '0;

            if (up_loss && RESYNC_CNT != 8'hFF)
                RESYNC_CNT <= RESYNC_CNT + 8'd1;

            // NOTE: outputs decode state_nx so they are registered yet match the state entered on this edge.
            LOCK_TIMEOUT_ERR <= timeout_hit;
            DEC_PASSTHROUGH  <= state_nx inside {IDLE, SETTLE, RESTART_DEC, FAIL};
            DEC_DATA_VALID   <= state_nx inside {HUNT, VERIFY, UP};
            LANE_UP          <= (state_nx == UP);
        end
    end

`ifdef LANE_SYNC_CANDIDATE_CHECK_EN
    always_ff @(posedge USER_CLK) begin
        if (SYSTEM_RESET)
            cand_q <= '0;
        else if (state == HUNT && state_nx == VERIFY)
            cand_q <= DEC_CANDIDATE;
    end
`endif

endmodule

// File: tb/tb_lane_sync_ctrl.sv
// Scoreboard bench for lane_sync_ctrl: a time-in-state reference model predicts every cycle's outputs.
// Directed phases cover settle/verify timing, timeouts to FAIL, resync saturation and candidate changes.
module tb_lane_sync_ctrl;

    localparam int SETTLE_CYCLES = 16;
    localparam int LOCK_TIMEOUT  = 1024;
    localparam int STABLE_CYCLES = 32;
    localparam int RESET_HOLD    = 4;
    localparam int MAX_RETRIES   = 4;

    localparam int S_IDLE = 0, S_SETTLE = 1, S_HUNT = 2, S_VERIFY = 3, S_RESTART = 4, S_UP = 5, S_FAIL = 6;

    logic       USER_CLK = 1'b0;
    logic       SYSTEM_RESET;
    logic       RX_READY;
    logic       RESTART;
    logic       DEC_LOCKED;
    logic [6:0] DEC_CANDIDATE;
    logic       DEC_PASSTHROUGH;
    logic       DEC_DATA_VALID;
    logic       LANE_UP;
    logic       LOCK_TIMEOUT_ERR;
    logic [7:0] RESYNC_CNT;
    logic [2:0] STATE_OUT;

    int checks   = 0;
    int failures = 0;

    // Reference model: state plus the edge index at which it was entered.
    int         m_state  = S_IDLE;
    int         m_since  = 0;
    int         m_retries = 0;
    int         m_resync = 0;
    bit         m_err    = 1'b0;
    logic [6:0] m_cand   = '0;
    int         edge_no  = 0;

    logic [14:0] sb[$];

    lane_sync_ctrl #(
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .RESET_HOLD   (RESET_HOLD),
        .MAX_RETRIES  (MAX_RETRIES)
    ) dut (
        .USER_CLK        (USER_CLK),
        .SYSTEM_RESET    (SYSTEM_RESET),
        .RX_READY        (RX_READY),
        .RESTART         (RESTART),
        .DEC_LOCKED      (DEC_LOCKED),
        .DEC_CANDIDATE   (DEC_CANDIDATE),
        .DEC_PASSTHROUGH (DEC_PASSTHROUGH),
        .DEC_DATA_VALID  (DEC_DATA_VALID),
        .LANE_UP         (LANE_UP),
        .LOCK_TIMEOUT_ERR(LOCK_TIMEOUT_ERR),
        .RESYNC_CNT      (RESYNC_CNT),
        .STATE_OUT       (STATE_OUT)
    );

    always #5 USER_CLK = ~USER_CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input bit rx, input bit rs, input bit lk,
                              input logic [6:0] cd);
        int spent;
        int nxt;
        bit lock_ok;
        edge_no++;
        m_err = 1'b0;
        if (rst) begin
            m_state   = S_IDLE;
            m_since   = edge_no;
            m_retries = 0;
            m_resync  = 0;
            m_cand    = '0;
            return;
        end
        spent   = edge_no - m_since;
        nxt     = m_state;
        lock_ok = lk;
`ifdef LANE_SYNC_CANDIDATE_CHECK_EN
        if (cd != m_cand) lock_ok = 1'b0;
`endif
        if (m_state != S_FAIL && !rx) begin
            nxt = S_IDLE;
            m_retries = 0;
        end else begin
            case (m_state)
                S_IDLE:   nxt = S_SETTLE;
                S_SETTLE: if (spent == SETTLE_CYCLES) nxt = S_HUNT;
                S_HUNT: begin
                    if (lk) begin
                        nxt = S_VERIFY;
                        m_cand = cd;
                    end else if (spent == LOCK_TIMEOUT) begin
                        nxt = S_RESTART;
                        m_err = 1'b1;
                        m_retries++;
                    end
                end
                S_RESTART: if (spent == RESET_HOLD) nxt = (m_retries == MAX_RETRIES) ? S_FAIL : S_HUNT;
                S_VERIFY: begin
                    if (!lock_ok) nxt = S_HUNT;
                    else if (spent == STABLE_CYCLES) begin
                        nxt = S_UP;
                        m_retries = 0;
                    end
                end
                S_UP: begin
                    if (!lock_ok) begin
                        nxt = S_HUNT;
                        if (m_resync < 255) m_resync++;
                    end
                end
                S_FAIL: if (rs) begin
                    nxt = S_IDLE;
                    m_retries = 0;
                end
                default: nxt = S_IDLE;
            endcase
        end
        if (nxt != m_state) m_since = edge_no;
        m_state = nxt;
    endtask

    function automatic logic [14:0] model_vec();
        logic [2:0] s;
        logic pt, dv, lu;
        s  = 3'(m_state);
        pt = (m_state == S_IDLE) || (m_state == S_SETTLE) || (m_state == S_RESTART) || (m_state == S_FAIL);
        dv = (m_state == S_HUNT) || (m_state == S_VERIFY) || (m_state == S_UP);
        lu = (m_state == S_UP);
        return {s, pt, dv, lu, m_err, 8'(m_resync)};
    endfunction

    // One clock: apply inputs, predict the post-edge outputs, then wait past the edge.
    task automatic drive(input bit rst, input bit rx, input bit rs, input bit lk, input logic [6:0] cd);
        SYSTEM_RESET  = rst;
        RX_READY      = rx;
        RESTART       = rs;
        DEC_LOCKED    = lk;
        DEC_CANDIDATE = cd;
        model_edge(rst, rx, rs, lk, cd);
        sb.push_back(model_vec());
        @(posedge USER_CLK);
        #1;
    endtask

    always @(negedge USER_CLK) begin
        if (sb.size() > 0) begin
            logic [14:0] exp_v;
            exp_v = sb.pop_front();
            check("cycle_outputs",
                  {17'd0, STATE_OUT, DEC_PASSTHROUGH, DEC_DATA_VALID, LANE_UP, LOCK_TIMEOUT_ERR, RESYNC_CNT},
                  {17'd0, exp_v});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int settle_n;
        int verify_n;
        int falls;
        int errs;
        int last_err;

        SYSTEM_RESET = 1'b1; RX_READY = 1'b0; RESTART = 1'b0; DEC_LOCKED = 1'b0; DEC_CANDIDATE = '0;

        // Reset state
        drive(1, 0, 0, 0, 7'd5);
        drive(1, 0, 0, 0, 7'd5);
        check("reset_state", STATE_OUT, 0);
        check("reset_passthrough", DEC_PASSTHROUGH, 1);
        check("reset_lane_up", LANE_UP, 0);

        // Bring-up with lock held: settle length and verify length
        settle_n = 0; verify_n = 0; n = 0;
        while (STATE_OUT != 3'd5 && n < 200) begin
            drive(0, 1, 0, 1, 7'd5);
            if (STATE_OUT == 3'd1) settle_n++;
            if (STATE_OUT == 3'd3) verify_n++;
            n++;
        end
        check("reached_up", STATE_OUT, 5);
        check("settle_len", settle_n, SETTLE_CYCLES);
        check("verify_len", verify_n, STABLE_CYCLES);
        check("resync_zero", RESYNC_CNT, 0);

        // Candidate change while up
        drive(0, 1, 0, 1, 7'd6);
`ifdef LANE_SYNC_CANDIDATE_CHECK_EN
        check("cand_change_state", STATE_OUT, 2);
        check("cand_change_resync", RESYNC_CNT, 1);
`else
        check("cand_change_state", STATE_OUT, 5);
        check("cand_change_resync", RESYNC_CNT, 0);
`endif
        n = 0;
        while (STATE_OUT != 3'd5 && n < 100) begin
            drive(0, 1, 0, 1, 7'd6);
            n++;
        end
        check("relock_after_cand", STATE_OUT, 5);

        // 300 single-cycle lock drops from UP
        falls = 0;
        for (int i = 0; i < 300; i++) begin
            drive(0, 1, 0, 0, 7'd6);
            if (!LANE_UP && STATE_OUT == 3'd2) falls++;
            n = 0;
            while (STATE_OUT != 3'd5 && n < 100) begin
                drive(0, 1, 0, 1, 7'd6);
                n++;
            end
        end
        check("up_drop_falls", falls, 300);
        check("resync_saturated", RESYNC_CNT, 255);

        // RX_READY glitch during VERIFY
        drive(0, 1, 0, 0, 7'd6);
        drive(0, 1, 0, 1, 7'd6);
        repeat (3) drive(0, 1, 0, 1, 7'd6);
        check("in_verify", STATE_OUT, 3);
        drive(0, 0, 0, 1, 7'd6);
        check("rx_drop_state", STATE_OUT, 0);
        check("rx_drop_passthrough", DEC_PASSTHROUGH, 1);

        // Lock never found: timeouts until FAIL
        errs = 0; last_err = -1; n = 0;
        while (STATE_OUT != 3'd6 && n < 6000) begin
            drive(0, 1, 0, 0, 7'd6);
            if (LOCK_TIMEOUT_ERR) begin
                errs++;
                if (last_err >= 0) check("timeout_period", edge_no - last_err, LOCK_TIMEOUT + RESET_HOLD);
                last_err = edge_no;
            end
            n++;
        end
        check("timeouts_before_fail", errs, MAX_RETRIES);
        check("fail_state", STATE_OUT, 6);
        repeat (3) drive(0, 0, 0, 0, 7'd6);
        check("fail_holds_without_rx", STATE_OUT, 6);
        drive(0, 1, 1, 0, 7'd6);
        check("restart_exit", STATE_OUT, 0);

        // Lock arriving on the final timer cycle wins over the timeout
        n = 0;
        while (!(m_state == S_HUNT && (edge_no + 1 - m_since) == LOCK_TIMEOUT) && n < 2000) begin
            drive(0, 1, 0, 0, 7'd5);
            n++;
        end
        check("reached_last_hunt_cycle", n < 2000, 1);
        drive(0, 1, 0, 1, 7'd5);
        check("late_lock_state", STATE_OUT, 3);
        check("late_lock_no_err", LOCK_TIMEOUT_ERR, 0);
        repeat (5) drive(0, 1, 0, 1, 7'd5);

        // Reset mid-operation
        drive(1, 1, 0, 1, 7'd5);
        check("midop_reset_state", STATE_OUT, 0);
        check("midop_reset_resync", RESYNC_CNT, 0);
        check("midop_reset_valid", DEC_DATA_VALID, 0);

        // Randomized traffic against the model
        begin
            bit lk;
            logic [6:0] cd;
            lk = 1'b0;
            cd = 7'd10;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(39, 0) == 0) lk = ~lk;
                if ($urandom_range(99, 0) == 0) cd = 7'($urandom_range(66, 0));
                drive($urandom_range(499, 0) == 0,
                      $urandom_range(99, 0) != 0,
                      $urandom_range(49, 0) == 0,
                      lk, cd);
            end
        end

        repeat (2) @(negedge USER_CLK);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
